// File: rtl/pipeline_hazard_ctrl.sv
// Stall, flush and forwarding control for the 5-stage pipeline, including the
// data-memory request/ack sequencer and the mult/div HI/LO busy counter.
module pipeline_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int REG_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_NeedRsByID,
    input  logic             ID_NeedRtByID,
    input  logic             ID_WantRsByEX,
    input  logic             ID_WantRtByEX,
    input  logic [REG_W-1:0] EX_Rs,
    input  logic [REG_W-1:0] EX_Rt,
    input  logic [REG_W-1:0] EX_RtRd,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic             EX_MulDivStart,
    input  logic             EX_MulDivUse,
    input  logic [REG_W-1:0] M_RtRd,
    input  logic             M_RegWrite,
    input  logic             M_MemRead,
    input  logic             M_MemWrite,
    input  logic [REG_W-1:0] WB_RtRd,
    input  logic             WB_RegWrite,
    input  logic             InstMem_Ready,
    input  logic             DataMem_Ack,
    input  logic             M_Exception,
    output logic             DataMem_Req,
    output logic             IF_Stall,
    output logic             ID_Stall,
    output logic             EX_Stall,
    output logic             M_Stall,
    output logic             WB_Stall,
    output logic             IF_Flush,
    output logic             ID_Flush,
    output logic             EX_Flush,
    output logic             M_Flush,
    output logic [1:0]       ID_RsFwdSel,
    output logic [1:0]       ID_RtFwdSel,
    output logic [1:0]       EX_RsFwdSel,
    output logic [1:0]       EX_RtFwdSel,
    output logic             MulDivBusy
);

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_ABORT} dmState_t;

    dmState_t         dmState, dmNext;
    logic [CNT_W-1:0] mulDivCnt;
    logic             memAcc, dmReq, dmStall, dmFlush;
    logic             mulDivBusyRaw, exStallRaw, mulDivLoad, hzId;

    function automatic logic regMatch(input logic wr, input logic [REG_W-1:0] dst,
                                      input logic [REG_W-1:0] src);
        return wr && (dst == src) && (src != '0);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] src);
        if (regMatch(M_RegWrite, M_RtRd, src))        return 2'b01;
        else if (regMatch(WB_RegWrite, WB_RtRd, src)) return 2'b10;
        else                                          return 2'b00;
    endfunction

    assign memAcc        = M_MemRead | M_MemWrite;
    assign mulDivBusyRaw = (mulDivCnt != '0);

    // An operand needed in ID cannot be forwarded from EX, nor from a load still in MEM.
    assign hzId = (ID_NeedRsByID & regMatch(EX_RegWrite, EX_RtRd, ID_Rs))
                | (ID_NeedRtByID & regMatch(EX_RegWrite, EX_RtRd, ID_Rt))
                | (ID_NeedRsByID & M_MemRead & regMatch(M_RegWrite, M_RtRd, ID_Rs))
                | (ID_NeedRtByID & M_MemRead & regMatch(M_RegWrite, M_RtRd, ID_Rt))
                | (ID_WantRsByEX & EX_MemRead & regMatch(EX_RegWrite, EX_RtRd, ID_Rs))
                | (ID_WantRtByEX & EX_MemRead & regMatch(EX_RegWrite, EX_RtRd, ID_Rt));

    assign exStallRaw = dmStall | (EX_MulDivUse & mulDivBusyRaw & ~M_Exception);
    assign mulDivLoad = EX_MulDivStart & ~exStallRaw;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        dmNext  = dmState;
        dmReq   = 1'b0;
        dmStall = 1'b0;
        dmFlush = 1'b0;
        case (dmState)
            DM_IDLE: begin
                if (memAcc) begin
                    dmReq = 1'b1;
                    if (!DataMem_Ack) begin
                        dmStall = ~M_Exception;
                        dmNext  = M_Exception ? DM_ABORT : DM_WAIT;
                    end
                end
            end
            DM_WAIT: begin
                dmReq = 1'b1;
                if (DataMem_Ack)      dmNext = DM_IDLE;
                else if (M_Exception) dmNext = DM_ABORT;
                else                  dmStall = 1'b1;
            end
            DM_ABORT: begin
                // The outstanding access cannot be cancelled; hold any new one back.
                dmReq   = 1'b1;
                dmFlush = 1'b1;
                dmStall = memAcc;
                if (DataMem_Ack) dmNext = DM_IDLE;
            end
            default: dmNext = DM_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmState   <= DM_IDLE;
            mulDivCnt <= '0;
        end else begin
            dmState <= dmNext;
            if (mulDivLoad)             mulDivCnt <= CNT_W'(MULDIV_CYCLES);
            else if (mulDivBusyRaw)     mulDivCnt <= mulDivCnt - CNT_W'(1);
        end
    end

    // NOTE: outputs are forced low while rst is high, so nothing pending leaks out during reset.
    always_comb begin
        DataMem_Req = 1'b0;
        IF_Stall    = 1'b0;
        ID_Stall    = 1'b0;
        EX_Stall    = 1'b0;
        M_Stall     = 1'b0;
        WB_Stall    = 1'b0;
        IF_Flush    = 1'b0;
        ID_Flush    = 1'b0;
        EX_Flush    = 1'b0;
        M_Flush     = 1'b0;
        ID_RsFwdSel = 2'b00;
        ID_RtFwdSel = 2'b00;
        EX_RsFwdSel = 2'b00;
        EX_RtFwdSel = 2'b00;
        MulDivBusy  = 1'b0;
        if (!rst) begin
            DataMem_Req = dmReq;
            M_Stall     = dmStall;
            EX_Stall    = exStallRaw;
            ID_Stall    = exStallRaw | (hzId & ~M_Exception);
            IF_Stall    = ID_Stall | ~InstMem_Ready;
            IF_Flush    = M_Exception;
            ID_Flush    = M_Exception;
            EX_Flush    = M_Exception;
            M_Flush     = M_Exception | dmFlush;
            ID_RsFwdSel = fwdSel(ID_Rs);
            ID_RtFwdSel = fwdSel(ID_Rt);
            EX_RsFwdSel = fwdSel(EX_Rs);
            EX_RtFwdSel = fwdSel(EX_Rt);
            MulDivBusy  = mulDivBusyRaw;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MULDIV_CYCLES=4; expected values
// are hand-computed per cycle and compared with immediate assertions.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_RtRd, M_RtRd, WB_RtRd;
    logic       ID_NeedRsByID, ID_NeedRtByID, ID_WantRsByEX, ID_WantRtByEX;
    logic       EX_RegWrite, EX_MemRead, EX_MulDivStart, EX_MulDivUse;
    logic       M_RegWrite, M_MemRead, M_MemWrite, WB_RegWrite;
    logic       InstMem_Ready, DataMem_Ack, M_Exception;
    logic       DataMem_Req, IF_Stall, ID_Stall, EX_Stall, M_Stall, WB_Stall;
    logic       IF_Flush, ID_Flush, EX_Flush, M_Flush, MulDivBusy;
    logic [1:0] ID_RsFwdSel, ID_RtFwdSel, EX_RsFwdSel, EX_RtFwdSel;

    logic [4:0]  stalls;
    logic [3:0]  flushes;
    logic [18:0] allOut;
    int          checks = 0;
    int          errors = 0;

    assign stalls  = {IF_Stall, ID_Stall, EX_Stall, M_Stall, WB_Stall};
    assign flushes = {IF_Flush, ID_Flush, EX_Flush, M_Flush};
    assign allOut  = {DataMem_Req, stalls, flushes, ID_RsFwdSel, ID_RtFwdSel,
                      EX_RsFwdSel, EX_RtFwdSel, MulDivBusy};

    pipeline_hazard_ctrl #(.MULDIV_CYCLES(4), .REG_W(5)) dut (
        .clk(clk), .rst(rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_NeedRsByID(ID_NeedRsByID), .ID_NeedRtByID(ID_NeedRtByID),
        .ID_WantRsByEX(ID_WantRsByEX), .ID_WantRtByEX(ID_WantRtByEX),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_RtRd(EX_RtRd),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_MulDivStart(EX_MulDivStart), .EX_MulDivUse(EX_MulDivUse),
        .M_RtRd(M_RtRd), .M_RegWrite(M_RegWrite), .M_MemRead(M_MemRead),
        .M_MemWrite(M_MemWrite), .WB_RtRd(WB_RtRd), .WB_RegWrite(WB_RegWrite),
        .InstMem_Ready(InstMem_Ready), .DataMem_Ack(DataMem_Ack),
        .M_Exception(M_Exception), .DataMem_Req(DataMem_Req),
        .IF_Stall(IF_Stall), .ID_Stall(ID_Stall), .EX_Stall(EX_Stall),
        .M_Stall(M_Stall), .WB_Stall(WB_Stall),
        .IF_Flush(IF_Flush), .ID_Flush(ID_Flush), .EX_Flush(EX_Flush),
        .M_Flush(M_Flush),
        .ID_RsFwdSel(ID_RsFwdSel), .ID_RtFwdSel(ID_RtFwdSel),
        .EX_RsFwdSel(EX_RsFwdSel), .EX_RtFwdSel(EX_RtFwdSel),
        .MulDivBusy(MulDivBusy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        {ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_RtRd, M_RtRd, WB_RtRd} = '0;
        {ID_NeedRsByID, ID_NeedRtByID, ID_WantRsByEX, ID_WantRtByEX} = '0;
        {EX_RegWrite, EX_MemRead, EX_MulDivStart, EX_MulDivUse} = '0;
        {M_RegWrite, M_MemRead, M_MemWrite, WB_RegWrite} = '0;
        {DataMem_Ack, M_Exception} = '0;
        InstMem_Ready = 1'b1;
    endtask

    initial begin
        // Reset with busy-looking inputs: every output must read 0.
        clearInputs();
        rst = 1'b1;
        M_MemRead = 1'b1; EX_MulDivStart = 1'b1; EX_MulDivUse = 1'b1; M_Exception = 1'b1;
        M_RegWrite = 1'b1; M_RtRd = 5'd5; EX_Rs = 5'd5; InstMem_Ready = 1'b0;
        nextCycle(); sample();
        check("reset_outputs", 32'(allOut), 32'h0);
        nextCycle(); clearInputs(); rst = 1'b0; sample();
        check("post_reset_outputs", 32'(allOut), 32'h0);

        // EX forwarding priority
        nextCycle(); clearInputs();
        EX_Rs = 5'd5; EX_Rt = 5'd9; M_RegWrite = 1'b1; M_RtRd = 5'd5;
        WB_RegWrite = 1'b1; WB_RtRd = 5'd5; sample();
        check("ex_rs_fwd_m", 32'(EX_RsFwdSel), 32'h1);
        check("ex_rt_no_match", 32'(EX_RtFwdSel), 32'h0);
        nextCycle(); M_RegWrite = 1'b0; sample();
        check("ex_rs_fwd_wb", 32'(EX_RsFwdSel), 32'h2);
        nextCycle(); M_RegWrite = 1'b1; EX_Rs = 5'd0; M_RtRd = 5'd0; WB_RtRd = 5'd0; sample();
        check("ex_rs_zero_reg", 32'(EX_RsFwdSel), 32'h0);
        nextCycle(); clearInputs(); ID_Rs = 5'd3; WB_RegWrite = 1'b1; WB_RtRd = 5'd3; sample();
        check("id_rs_fwd_wb", 32'(ID_RsFwdSel), 32'h2);
        check("id_fwd_no_stall", 32'(stalls), 32'h0);

        // ID branch operands against EX and a load in MEM
        nextCycle(); clearInputs();
        ID_Rs = 5'd4; ID_NeedRsByID = 1'b1; EX_RegWrite = 1'b1; EX_RtRd = 5'd4; sample();
        check("hz_need_rs_ex", 32'(stalls), 32'b11000);
        nextCycle(); clearInputs();
        ID_Rt = 5'd6; ID_NeedRtByID = 1'b1; M_RegWrite = 1'b1; M_MemRead = 1'b1;
        M_RtRd = 5'd6; DataMem_Ack = 1'b1; sample();
        check("hz_need_rt_mload", 32'(stalls), 32'b11000);
        check("zero_wait_req", 32'(DataMem_Req), 32'h1);

        // Load-use, then the load in MEM forwards to ID
        nextCycle(); clearInputs();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_RtRd = 5'd7; ID_Rt = 5'd7;
        ID_WantRtByEX = 1'b1; sample();
        check("load_use_stall", 32'(stalls), 32'b11000);
        nextCycle(); clearInputs();
        ID_Rt = 5'd7; ID_WantRtByEX = 1'b1; M_RegWrite = 1'b1; M_MemRead = 1'b1;
        M_RtRd = 5'd7; DataMem_Ack = 1'b1; sample();
        check("load_use_clear", 32'(stalls), 32'b00000);
        check("load_use_fwd", 32'(ID_RtFwdSel), 32'h1);
        nextCycle(); clearInputs();
        EX_RegWrite = 1'b1; EX_RtRd = 5'd7; ID_Rt = 5'd7; ID_WantRtByEX = 1'b1; sample();
        check("non_load_no_stall", 32'(stalls), 32'b00000);
        nextCycle(); clearInputs(); InstMem_Ready = 1'b0; sample();
        check("imem_not_ready", 32'(stalls), 32'b10000);

        // Memory wait: ack in cycle 3
        for (int c = 0; c < 5; c++) begin
            nextCycle(); clearInputs();
            M_MemRead = (c < 4); DataMem_Ack = (c == 3); sample();
            check($sformatf("wait_req_c%0d", c), 32'(DataMem_Req), (c < 4) ? 32'h1 : 32'h0);
            check($sformatf("wait_stall_c%0d", c), 32'(stalls), (c < 3) ? 32'b11110 : 32'b00000);
        end
        nextCycle(); clearInputs(); M_MemWrite = 1'b1; DataMem_Ack = 1'b1; sample();
        check("zero_wait_stall", 32'(stalls), 32'b00000);
        nextCycle(); clearInputs(); sample();
        check("zero_wait_idle", 32'(DataMem_Req), 32'h0);

        // Abort: exception in cycle 1, ack in cycle 4, new access held in cycle 3
        nextCycle(); clearInputs(); M_MemRead = 1'b1; sample();
        check("abort_c0_stall", 32'(stalls), 32'b11110);
        nextCycle(); clearInputs(); M_MemRead = 1'b1; M_Exception = 1'b1;
        ID_Rs = 5'd4; ID_NeedRsByID = 1'b1; EX_RegWrite = 1'b1; EX_RtRd = 5'd4; sample();
        check("abort_c1_flush", 32'(flushes), 32'b1111);
        check("abort_c1_stall", 32'(stalls), 32'b00000);
        check("abort_c1_req", 32'(DataMem_Req), 32'h1);
        for (int c = 2; c < 5; c++) begin
            nextCycle(); clearInputs(); M_MemRead = (c == 3); DataMem_Ack = (c == 4); sample();
            check($sformatf("abort_c%0d_req", c), 32'(DataMem_Req), 32'h1);
            check($sformatf("abort_c%0d_flush", c), 32'(flushes), 32'b0001);
            check($sformatf("abort_c%0d_stall", c), 32'(stalls), (c == 3) ? 32'b11110 : 32'b00000);
        end
        nextCycle(); clearInputs(); sample();
        check("abort_c5_idle", {28'h0, DataMem_Req, flushes[0], M_Stall, 1'b0}, 32'h0);

        // Ack and exception together in DM_WAIT return to idle
        nextCycle(); clearInputs(); M_MemRead = 1'b1; sample();
        nextCycle(); M_Exception = 1'b1; DataMem_Ack = 1'b1; sample();
        check("ack_exc_flush", 32'(flushes), 32'b1111);
        nextCycle(); clearInputs(); sample();
        check("ack_exc_idle", {30'h0, DataMem_Req, M_Flush}, 32'h0);

        // Reset mid-wait drops the request and leaves nothing pending
        nextCycle(); clearInputs(); M_MemRead = 1'b1; sample();
        nextCycle(); rst = 1'b1; sample();
        check("rst_mid_wait_req", 32'(DataMem_Req), 32'h0);
        nextCycle(); clearInputs(); rst = 1'b0; sample();
        check("rst_mid_wait_after", {26'h0, DataMem_Req, stalls}, 32'h0);

        // Mult/div: issue in cycle 0, HI/LO user from cycle 1, exception masks cycle 4
        nextCycle(); clearInputs(); EX_MulDivStart = 1'b1; EX_MulDivUse = 1'b1; sample();
        check("md_issue_stall", 32'(stalls), 32'b00000);
        for (int c = 1; c < 6; c++) begin
            nextCycle(); clearInputs(); EX_MulDivUse = 1'b1; M_Exception = (c == 4); sample();
            check($sformatf("md_busy_c%0d", c), 32'(MulDivBusy), (c < 5) ? 32'h1 : 32'h0);
            check($sformatf("md_stall_c%0d", c), 32'(stalls),
                  (c < 4) ? 32'b11100 : 32'b00000);
        end

        // Reset during busy clears the counter
        nextCycle(); clearInputs(); EX_MulDivStart = 1'b1; EX_MulDivUse = 1'b1; sample();
        nextCycle(); clearInputs(); EX_MulDivUse = 1'b1; sample();
        check("md_rst_busy_c1", 32'(MulDivBusy), 32'h1);
        nextCycle(); rst = 1'b1; sample();
        check("md_rst_c2_outputs", 32'(allOut), 32'h0);
        nextCycle(); rst = 1'b0; sample();
        check("md_rst_c3_busy", 32'(MulDivBusy), 32'h0);
        check("md_rst_c3_stall", 32'(EX_Stall), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
